display_layout_scheduler: RTL and testbench

// Sits between the 640x480 timing generator and NUM_CAM QVGA (320x240) camera frame buffers.

---
 rtl/display_layout_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_display_layout_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_layout_scheduler.sv
// Display layout scheduler: turns 640x480 timing into per-pixel camera frame-buffer
// reads (full-screen 2x upscale or 2x2 quad) and muxes the returned pixel back in step.

module display_layout_lane #(
  parameter int PIX_W = 12,
  parameter int CW    = 2,
  parameter int IDX   = 0
) (
  input  logic [CW-1:0]    sel,
  input  logic [PIX_W-1:0] data,
  output logic [PIX_W-1:0] q
);
  assign q = (sel == CW'(IDX)) ? data : '0;
endmodule

module display_layout_scheduler #(
  parameter int               NUM_CAM      = 4,
  parameter int               PIX_W        = 12,
  parameter int               RD_LATENCY   = 1,
  parameter logic [2:0]       RESET_MODE   = 3'd4,
  parameter logic [PIX_W-1:0] BORDER_COLOR = 12'hFFF
) (
  input  logic                     pclk,
  input  logic                     rstn,
  input  logic [9:0]               x_pixel,
  input  logic [9:0]               y_pixel,
  input  logic                     de_in,
  input  logic                     h_sync_in,
  input  logic                     v_sync_in,
  input  logic                     cfg_valid,
  input  logic [2:0]               cfg_mode,
  output logic                     cfg_ready,
  output logic [2:0]               active_mode,
  output logic [NUM_CAM-1:0]       rd_en,
  output logic [16:0]              rd_addr,
  input  logic [NUM_CAM*PIX_W-1:0] rd_data,
  output logic [PIX_W-1:0]         rgb_out,
  output logic                     de_out,
  output logic                     h_sync_out,
  output logic                     v_sync_out
);
  localparam int CW = $clog2(NUM_CAM);

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic          bdr;
    logic [CW-1:0] cam;
  } side_t;

  localparam side_t SB_RST = '{de: 1'b0, hs: 1'b1, vs: 1'b1, bdr: 1'b0, cam: '0};

  typedef enum logic {IDLE, PENDING} cfg_st_t;

  // ---------------- layout config FSM ----------------
  cfg_st_t    st;
  logic [2:0] pending;
  logic       vs_q;

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      st          <= IDLE;
      cfg_ready   <= 1'b1;
      active_mode <= RESET_MODE;
      pending     <= RESET_MODE;
      vs_q        <= 1'b1;
    end else begin
      vs_q <= v_sync_in;
      case (st)
        IDLE: begin
          // reserved modes complete the handshake but are dropped
          if (cfg_valid && cfg_ready && cfg_mode <= 3'd4) begin
            pending   <= cfg_mode;
            st        <= PENDING;
            cfg_ready <= 1'b0;
          end
        end
        PENDING: begin
          if (vs_q && !v_sync_in) begin
            active_mode <= pending;
            st          <= IDLE;
            cfg_ready   <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  // ---------------- stage 1: camera select and address ----------------
  logic          quad, qx, qy, border;
  logic [9:0]    col, row;
  logic [CW-1:0] cam_n;
  logic [16:0]   r17, addr_n;

  always_comb begin
    quad   = (active_mode == 3'd4);
    qx     = (x_pixel >= 10'd320);
    qy     = (y_pixel >= 10'd240);
    col    = {1'b0, x_pixel[9:1]};
    row    = {1'b0, y_pixel[9:1]};
    cam_n  = active_mode[CW-1:0];
    border = 1'b0;
    if (quad) begin
      col    = qx ? x_pixel - 10'd320 : x_pixel;
      row    = qy ? y_pixel - 10'd240 : y_pixel;
      cam_n  = CW'({qy, qx});
      border = (x_pixel == 10'd319) || (x_pixel == 10'd320) ||
               (y_pixel == 10'd239) || (y_pixel == 10'd240);
    end
    r17    = 17'(row);
    addr_n = (r17 << 8) + (r17 << 6) + 17'(col);
  end

  // sb_pipe[0] is the stage-1 sideband; [RD_LATENCY] lines up with rd_data
  side_t [RD_LATENCY:0] sb_pipe;

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      rd_en      <= '0;
      rd_addr    <= '0;
      sb_pipe[0] <= SB_RST;
    end else begin
      sb_pipe[0] <= '{de: de_in, hs: h_sync_in, vs: v_sync_in,
                      bdr: de_in && border, cam: cam_n};
      if (de_in && !border) begin
        rd_en   <= NUM_CAM'(1) << cam_n;
        rd_addr <= addr_n;
      end else begin
        rd_en   <= '0;
      end
    end
  end

  generate
    for (genvar k = 1; k <= RD_LATENCY; k++) begin : g_dly
      always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) sb_pipe[k] <= SB_RST;
        else       sb_pipe[k] <= sb_pipe[k-1];
      end
    end
  endgenerate

  // ---------------- stage 2: pixel mux ----------------
  logic [NUM_CAM-1:0][PIX_W-1:0] rd_vec, lane_q;
  logic [PIX_W-1:0]              mux_q;
  side_t                         sb_l;

  assign rd_vec = rd_data;
  assign sb_l   = sb_pipe[RD_LATENCY];

  generate
    for (genvar g = 0; g < NUM_CAM; g++) begin : g_lane
      display_layout_lane #(.PIX_W(PIX_W), .CW(CW), .IDX(g)) u_lane (
        .sel  (sb_l.cam),
        .data (rd_vec[g]),
        .q    (lane_q[g])
      );
    end
  endgenerate

  always_comb begin
    mux_q = '0;
    for (int i = 0; i < NUM_CAM; i++) mux_q |= lane_q[i];
  end

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      rgb_out    <= '0;
      de_out     <= 1'b0;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b1;
    end else begin
      de_out     <= sb_l.de;
      h_sync_out <= sb_l.hs;
      v_sync_out <= sb_l.vs;
      if (!sb_l.de)     rgb_out <= '0;
      else if (sb_l.bdr) rgb_out <= BORDER_COLOR;
      else              rgb_out <= mux_q;
    end
  end

endmodule

// File: tb/tb_display_layout_scheduler.sv
// Directed bench for display_layout_scheduler: two instances (read latency 1 and 3)
// fed from identical timing, each backed by a frame-buffer model tagging data with cam/address.

module tb_display_layout_scheduler;
  logic        pclk = 1'b0;
  logic        rstn;
  logic [9:0]  x_pixel, y_pixel;
  logic        de_in, h_sync_in, v_sync_in, cfg_valid;
  logic [2:0]  cfg_mode;

  logic        rdy1, rdy3, de1, de3, hs1, hs3, vs1, vs3;
  logic [2:0]  am1, am3;
  logic [3:0]  rd_en1, rd_en3;
  logic [16:0] rd_addr1, rd_addr3;
  logic [47:0] rd_data1, rd_data3;
  logic [11:0] rgb1, rgb3;

  int vectors = 0;
  int miscompares = 0;

  always #5 pclk = ~pclk;

  display_layout_scheduler #(.RD_LATENCY(1)) u1 (
    .pclk(pclk), .rstn(rstn), .x_pixel(x_pixel), .y_pixel(y_pixel), .de_in(de_in),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_ready(rdy1), .active_mode(am1), .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .rgb_out(rgb1), .de_out(de1), .h_sync_out(hs1), .v_sync_out(vs1));

  display_layout_scheduler #(.RD_LATENCY(3)) u3 (
    .pclk(pclk), .rstn(rstn), .x_pixel(x_pixel), .y_pixel(y_pixel), .de_in(de_in),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode),
    .cfg_ready(rdy3), .active_mode(am3), .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .rgb_out(rgb3), .de_out(de3), .h_sync_out(hs3), .v_sync_out(vs3));

  // Frame buffer model: valid slice = {cam[1:0], addr[9:0]}, everything else 12'hBAD.
  function automatic logic [47:0] fbdata(input logic [3:0] en, input logic [9:0] a);
    logic [47:0] r;
    r = {4{12'hBAD}};
    for (int i = 0; i < 4; i++)
      if (en[i]) r[i*12 +: 12] = {2'(i), a};
    return r;
  endfunction

  logic [3:0] en1_q;
  logic [9:0] a1_q;
  logic [3:0] en3_q [3];
  logic [9:0] a3_q  [3];

  always @(posedge pclk) begin
    en1_q <= rd_en1;   a1_q <= rd_addr1[9:0];
    en3_q[0] <= rd_en3; a3_q[0] <= rd_addr3[9:0];
    en3_q[1] <= en3_q[0]; a3_q[1] <= a3_q[0];
    en3_q[2] <= en3_q[1]; a3_q[2] <= a3_q[1];
  end

  assign rd_data1 = fbdata(en1_q, a1_q);
  assign rd_data3 = fbdata(en3_q[2], a3_q[2]);

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input logic de);
    x_pixel = 10'(x);
    y_pixel = 10'(y);
    de_in   = de;
  endtask

  initial begin
    rstn = 1'b0; x_pixel = '0; y_pixel = '0; de_in = 1'b0;
    h_sync_in = 1'b1; v_sync_in = 1'b1; cfg_valid = 1'b0; cfg_mode = 3'd0;
    tick(); tick(); tick();

    // reset state
    chk("rst_rd_en", rd_en1, 4'b0000);
    chk("rst_rd_addr", rd_addr1, 17'd0);
    chk("rst_rgb", rgb1, 12'h000);
    chk("rst_de", de1, 1'b0);
    chk("rst_hs", hs1, 1'b1);
    chk("rst_vs", vs1, 1'b1);
    chk("rst_ready", rdy1, 1'b1);
    chk("rst_mode", am1, 3'd4);
    rstn = 1'b1;
    tick(); tick();

    // quad cam3 pixel with an hsync pulse; latency 3 (u1) and 5 (u3)
    pix(330, 250, 1'b1); h_sync_in = 1'b0;
    tick();
    chk("q_rd_en", rd_en1, 4'b1000);
    chk("q_rd_addr", rd_addr1, 17'd3210);
    pix(330, 250, 1'b0); h_sync_in = 1'b1;
    tick();
    chk("q_addr_hold", rd_addr1, 17'd3210);
    chk("q_rd_en_off", rd_en1, 4'b0000);
    chk("lat1_de_t2", de1, 1'b0);
    chk("lat1_hs_t2", hs1, 1'b1);
    tick();
    chk("lat1_de_t3", de1, 1'b1);
    chk("lat1_hs_t3", hs1, 1'b0);
    chk("lat1_rgb_t3", rgb1, 12'hC8A);
    tick();
    chk("lat1_de_t4", de1, 1'b0);
    chk("lat1_rgb_t4", rgb1, 12'h000);
    chk("lat3_de_t4", de3, 1'b0);
    chk("lat3_hs_t4", hs3, 1'b1);
    tick();
    chk("lat3_de_t5", de3, 1'b1);
    chk("lat3_hs_t5", hs3, 1'b0);
    chk("lat3_rgb_t5", rgb3, 12'hC8A);
    tick();
    chk("lat3_de_t6", de3, 1'b0);

    // quad borders then a normal cam0 pixel then blanking
    pix(320, 100, 1'b1);
    tick();
    chk("bdr_x_rd_en", rd_en1, 4'b0000);
    pix(10, 239, 1'b1);
    tick();
    chk("bdr_y_rd_en", rd_en1, 4'b0000);
    pix(5, 5, 1'b1);
    tick();
    chk("bdr_x_rgb", rgb1, 12'hFFF);
    chk("c0_rd_en", rd_en1, 4'b0001);
    chk("c0_rd_addr", rd_addr1, 17'd1605);
    pix(5, 5, 1'b0);
    tick();
    chk("bdr_y_rgb", rgb1, 12'hFFF);
    tick();
    chk("c0_rgb", rgb1, 12'h245);
    tick();
    chk("blank_rgb", rgb1, 12'h000);
    chk("blank_de", de1, 1'b0);

    // switch to full-screen cam2, applied only at vsync falling edge
    y_pixel = 10'd100; cfg_valid = 1'b1; cfg_mode = 3'd2;
    tick();
    cfg_valid = 1'b0;
    chk("cfg_busy", rdy1, 1'b0);
    chk("cfg_hold_mode", am1, 3'd4);
    y_pixel = 10'd490;
    tick(); tick();
    chk("cfg_still_quad", am1, 3'd4);
    v_sync_in = 1'b0;
    tick();
    chk("cfg_applied", am1, 3'd2);
    chk("cfg_ready_back", rdy1, 1'b1);
    v_sync_in = 1'b1;
    tick();

    // full cam2, 2x upscale incl. last address
    pix(101, 51, 1'b1);
    tick();
    chk("f_rd_en", rd_en1, 4'b0100);
    chk("f_rd_addr", rd_addr1, 17'd8050);
    pix(639, 479, 1'b1);
    tick();
    chk("f_last_addr", rd_addr1, 17'd76799);
    pix(639, 479, 1'b0);
    tick();
    chk("f_rgb0", rgb1, 12'hB72);
    tick();
    chk("f_rgb1", rgb1, 12'hBFF);
    tick();
    chk("f_rgb_blank", rgb1, 12'h000);

    // reserved mode: accepted and dropped
    cfg_valid = 1'b1; cfg_mode = 3'd6;
    tick();
    cfg_valid = 1'b0;
    chk("rsv_ready", rdy1, 1'b1);
    v_sync_in = 1'b0;
    tick();
    v_sync_in = 1'b1;
    tick();
    chk("rsv_mode", am1, 3'd2);

    // request on the boundary cycle waits a full frame
    v_sync_in = 1'b0; cfg_valid = 1'b1; cfg_mode = 3'd4;
    tick();
    cfg_valid = 1'b0;
    chk("bnd_ready", rdy1, 1'b0);
    chk("bnd_not_applied", am1, 3'd2);
    tick();
    v_sync_in = 1'b1;
    tick();
    chk("bnd_still_old", am1, 3'd2);
    v_sync_in = 1'b0;
    tick();
    chk("bnd_next_frame", am1, 3'd4);
    v_sync_in = 1'b1;
    tick();

    // reset while a request is pending
    cfg_valid = 1'b1; cfg_mode = 3'd0;
    tick();
    cfg_valid = 1'b0;
    chk("pend_ready", rdy1, 1'b0);
    pix(5, 5, 1'b1); h_sync_in = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    chk("mid_rst_rd_en", rd_en1, 4'b0000);
    chk("mid_rst_mode", am1, 3'd4);
    chk("mid_rst_ready", rdy1, 1'b1);
    chk("mid_rst_de3", de3, 1'b0);
    chk("mid_rst_hs3", hs3, 1'b1);
    chk("mid_rst_vs3", vs3, 1'b1);
    chk("mid_rst_rgb3", rgb3, 12'h000);
    chk("mid_rst_mode3", am3, 3'd4);
    chk("mid_rst_ready3", rdy3, 1'b1);
    pix(0, 0, 1'b0); h_sync_in = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    v_sync_in = 1'b0;
    tick();
    v_sync_in = 1'b1;
    chk("pend_dropped", am1, 3'd4);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
